store_queue_mp: RTL and testbench

// - Multi-port successor store queue for the OoO LSU. Circular buffer of in-flight stores.
// - Allocates up to ALLOC_WIDTH stores per cycle in program order.
// - Captures address (AGU) and data (CDB); marks entries committed by ROB tag over COMMIT_WIDTH lanes.
// - Issues the oldest committed store to memory via valid/ready; retires in order at the head.
// - Flushes all uncommitted entries on mispredict.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/stq_oldest_select.sv | 36 +++
 rtl/store_queue_mp.sv | 217 +++++++++++++++++++++
 tb/tb_store_queue_mp.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types and helpers: store-queue entry layout, access sizes,
// byte-enable generation and alignment checking.
package lsu_pkg;

   localparam int LSU_XLEN          = 32;
   localparam int LSU_ROB_TAG_WIDTH = 5;
   localparam int LSU_MASK_W        = LSU_XLEN / 8;
   localparam int LSU_OFF_W         = $clog2(LSU_MASK_W);

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic                         valid;
      logic [LSU_XLEN-1:0]          addr;
      logic                         addr_valid;
      logic [LSU_XLEN-1:0]          data;
      logic                         data_valid;
      mem_size_e                    size;
      logic                         committed;
      logic                         executed;
      logic                         succeeded;
      logic [LSU_ROB_TAG_WIDTH-1:0] rob_tag;
   } stq_entry_t;

   // Bytes outside the word are dropped by the final truncation.
   function automatic logic [LSU_MASK_W-1:0] size_mask(input mem_size_e size,
                                                      input logic [LSU_OFF_W-1:0] off);
      return LSU_MASK_W'(((64'd1 << (7'd1 << size)) - 64'd1) << off);
   endfunction

   function automatic logic misaligned_chk(input mem_size_e size, input logic [2:0] addr);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr[0];
         SZ_W:    bad = |addr[1:0];
         default: bad = |addr[2:0];
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/stq_oldest_select.sv
// Oldest-first selector over a circular buffer: rotate the request bits so
// head is bit 0, pick the lowest set bit, then rotate the index back.
module stq_oldest_select #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] head,
   output logic [IW-1:0] idx,
   output logic          hit
);

   logic [N-1:0]  rot;
   logic [IW-1:0] enc;

   always_comb begin
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req[head + IW'(i)];
      end
   end

   always_comb begin
      enc = '0;
      hit = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            enc = IW'(i);
            hit = 1'b1;
         end
      end
   end

   assign idx = enc + head;

endmodule

// File: rtl/store_queue_mp.sv
// Multi-port store queue: in-order allocation, tag-matched AGU/CDB/commit
// updates, oldest-first issue and in-order retire. STQ_CDB_BYPASS_EN enables
// same-cycle AGU/CDB capture on allocating lanes.
module store_queue_mp
   import lsu_pkg::*;
#(
   parameter int XLEN          = LSU_XLEN,
   parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_WIDTH,
   parameter int STQ_SIZE      = 16,
   parameter int ALLOC_WIDTH   = 2,
   parameter int COMMIT_WIDTH  = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [ALLOC_WIDTH-1:0]                alloc_valid,
   input  logic [ALLOC_WIDTH*ROB_TAG_WIDTH-1:0]  alloc_rob_tag,
   input  logic [ALLOC_WIDTH*2-1:0]              alloc_size,
   input  logic [ALLOC_WIDTH*XLEN-1:0]           alloc_data,
   input  logic [ALLOC_WIDTH-1:0]                alloc_data_valid,
   output logic                                  alloc_ready,
   input  logic                                  agu_valid,
   input  logic [ROB_TAG_WIDTH-1:0]              agu_rob_tag,
   input  logic [XLEN-1:0]                       agu_address,
   input  logic                                  cdb_active,
   input  logic [ROB_TAG_WIDTH-1:0]              cdb_tag,
   input  logic [XLEN-1:0]                       cdb_data,
   input  logic [COMMIT_WIDTH-1:0]               commit_valid,
   input  logic [COMMIT_WIDTH*ROB_TAG_WIDTH-1:0] commit_tag,
   input  logic                                  flush,
   output logic                                  mem_req_valid,
   input  logic                                  mem_req_ready,
   output logic [XLEN-1:0]                       mem_req_addr,
   output logic [XLEN-1:0]                       mem_req_data,
   output logic [XLEN/8-1:0]                     mem_req_mask,
   output logic [$clog2(STQ_SIZE)-1:0]           mem_req_idx,
   input  logic                                  mem_resp_valid,
   input  logic [$clog2(STQ_SIZE)-1:0]           mem_resp_idx,
   output logic                                  misaligned,
   output logic [ROB_TAG_WIDTH-1:0]              misaligned_rob_tag,
   output logic [$clog2(STQ_SIZE)-1:0]           head,
   output logic [$clog2(STQ_SIZE)-1:0]           tail,
   output logic [$clog2(STQ_SIZE):0]             count,
   output logic                                  empty,
   output logic                                  full
);

   localparam int IW  = $clog2(STQ_SIZE);
   localparam int CW  = IW + 1;
   localparam int RTW = ROB_TAG_WIDTH;
   localparam int OW  = $clog2(XLEN / 8);

   stq_entry_t          ent   [STQ_SIZE];
   stq_entry_t          ent_n [STQ_SIZE];
   stq_entry_t          fresh;
   stq_entry_t          req_ent;

   logic [IW-1:0]       head_n, tail_n, slot;
   logic [CW-1:0]       count_n;
   logic                req_valid, req_valid_n;
   logic [IW-1:0]       req_idx, req_idx_n;
   logic                mis_q, mis_n;
   logic [RTW-1:0]      mis_tag_q, mis_tag_n;
   logic [STQ_SIZE-1:0] commit_hit, pending;
   logic [IW-1:0]       old_idx;
   logic                old_hit, cand_ok, req_fire, retire;
   logic [OW-1:0]       req_off;
   int                  nalloc, nkeep;

   assign alloc_ready = (count <= CW'(STQ_SIZE - ALLOC_WIDTH));
   assign empty       = (count == '0);
   assign full        = (count == CW'(STQ_SIZE));
   assign req_fire    = req_valid & mem_req_ready;
   assign retire      = ent[head].valid & ent[head].succeeded;

   always_comb begin
      commit_hit = '0;
      for (int i = 0; i < STQ_SIZE; i++) begin
         for (int l = 0; l < COMMIT_WIDTH; l++) begin
            if (ent[i].valid && commit_valid[l] && ent[i].rob_tag == commit_tag[l*RTW +: RTW])
               commit_hit[i] = 1'b1;
         end
      end
   end

   // The entry being handed off this cycle is treated as already executed.
   always_comb begin
      pending = '0;
      for (int i = 0; i < STQ_SIZE; i++) begin
         pending[i] = ent[i].valid & ~ent[i].executed & ~(req_fire && req_idx == IW'(i));
      end
   end

   stq_oldest_select #(.N(STQ_SIZE), .IW(IW)) u_oldest (
      .req  (pending),
      .head (head),
      .idx  (old_idx),
      .hit  (old_hit)
   );

   // Only the oldest unexecuted entry may issue, which enforces the
   // all-predecessors-executed rule without a separate scan.
   assign cand_ok = old_hit & ent[old_idx].committed & ent[old_idx].addr_valid
                    & ent[old_idx].data_valid;

   always_comb begin
      if (req_valid && !mem_req_ready) begin
         req_valid_n = 1'b1;
         req_idx_n   = req_idx;
      end else begin
         req_valid_n = cand_ok;
         req_idx_n   = old_idx;
      end
   end

   always_comb begin
      for (int i = 0; i < STQ_SIZE; i++) ent_n[i] = ent[i];
      fresh     = '0;
      slot      = tail;
      mis_n     = 1'b0;
      mis_tag_n = agu_rob_tag;
      nalloc    = 0;
      nkeep     = 0;

      for (int i = 0; i < STQ_SIZE; i++) begin
         if (ent[i].valid) begin
            if (agu_valid && ent[i].rob_tag == agu_rob_tag) begin
               ent_n[i].addr       = agu_address;
               ent_n[i].addr_valid = 1'b1;
               if (misaligned_chk(ent[i].size, agu_address[2:0])) mis_n = 1'b1;
            end
            if (cdb_active && ent[i].rob_tag == cdb_tag) begin
               ent_n[i].data       = cdb_data;
               ent_n[i].data_valid = 1'b1;
            end
            if (commit_hit[i]) ent_n[i].committed = 1'b1;
         end
      end

      if (req_fire) ent_n[req_idx].executed = 1'b1;
      if (mem_resp_valid && ent[mem_resp_idx].valid) ent_n[mem_resp_idx].succeeded = 1'b1;
      if (retire) ent_n[head] = '0;

      if (flush) begin
         for (int i = 0; i < STQ_SIZE; i++) begin
            if (!(ent[i].committed || commit_hit[i])) ent_n[i] = '0;
            else if (ent[i].valid) nkeep++;
         end
      end else if (alloc_ready) begin
         for (int l = 0; l < ALLOC_WIDTH; l++) begin
            if (alloc_valid[l]) begin
               slot             = tail + IW'(nalloc);
               fresh            = '0;
               fresh.valid      = 1'b1;
               fresh.rob_tag    = alloc_rob_tag[l*RTW +: RTW];
               fresh.size       = mem_size_e'(alloc_size[l*2 +: 2]);
               fresh.data       = alloc_data[l*XLEN +: XLEN];
               fresh.data_valid = alloc_data_valid[l];
`ifdef STQ_CDB_BYPASS_EN
               if (cdb_active && cdb_tag == fresh.rob_tag) begin
                  fresh.data       = cdb_data;
                  fresh.data_valid = 1'b1;
               end
               if (agu_valid && agu_rob_tag == fresh.rob_tag) begin
                  fresh.addr       = agu_address;
                  fresh.addr_valid = 1'b1;
                  if (misaligned_chk(fresh.size, agu_address[2:0])) mis_n = 1'b1;
               end
`endif
               ent_n[slot] = fresh;
               nalloc++;
            end
         end
      end

      head_n = head + IW'(retire);
      if (flush) begin
         tail_n  = head + IW'(nkeep);
         count_n = CW'(nkeep) - CW'(retire);
      end else begin
         tail_n  = tail + IW'(nalloc);
         count_n = count + CW'(nalloc) - CW'(retire);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < STQ_SIZE; i++) ent[i] <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         req_valid <= 1'b0;
         req_idx   <= '0;
         mis_q     <= 1'b0;
         mis_tag_q <= '0;
      end else begin
         for (int i = 0; i < STQ_SIZE; i++) ent[i] <= ent_n[i];
         head      <= head_n;
         tail      <= tail_n;
         count     <= count_n;
         req_valid <= req_valid_n;
         req_idx   <= req_idx_n;
         mis_q     <= mis_n;
         mis_tag_q <= mis_tag_n;
      end
   end

   assign req_ent            = ent[req_idx];
   assign req_off            = req_ent.addr[OW-1:0];
   assign mem_req_valid      = req_valid;
   assign mem_req_idx        = req_idx;
   assign mem_req_addr       = {req_ent.addr[XLEN-1:OW], {OW{1'b0}}};
   assign mem_req_mask       = size_mask(req_ent.size, req_off);
   assign mem_req_data       = req_ent.data << {req_off, 3'b000};
   assign misaligned         = mis_q;
   assign misaligned_rob_tag = mis_tag_q;

endmodule

// File: tb/tb_store_queue_mp.sv
// Directed bench for store_queue_mp: allocation, issue/hold/retire, byte lanes,
// misalignment, flush, wrap-around under load and the optional CDB bypass.
module tb_store_queue_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  alloc_valid;
   logic [9:0]  alloc_rob_tag;
   logic [3:0]  alloc_size;
   logic [63:0] alloc_data;
   logic [1:0]  alloc_data_valid;
   logic        alloc_ready;
   logic        agu_valid;
   logic [4:0]  agu_rob_tag;
   logic [31:0] agu_address;
   logic        cdb_active;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [1:0]  commit_valid;
   logic [9:0]  commit_tag;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic [3:0]  mem_req_idx;
   logic        mem_resp_valid;
   logic [3:0]  mem_resp_idx;
   logic        misaligned;
   logic [4:0]  misaligned_rob_tag;
   logic [3:0]  head, tail;
   logic [4:0]  count;
   logic        empty, full;

   int n_cmp = 0;
   int n_bad = 0;

   store_queue_mp dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag), .alloc_size(alloc_size),
      .alloc_data(alloc_data), .alloc_data_valid(alloc_data_valid), .alloc_ready(alloc_ready),
      .agu_valid(agu_valid), .agu_rob_tag(agu_rob_tag), .agu_address(agu_address),
      .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_req_idx(mem_req_idx), .mem_resp_valid(mem_resp_valid), .mem_resp_idx(mem_resp_idx),
      .misaligned(misaligned), .misaligned_rob_tag(misaligned_rob_tag),
      .head(head), .tail(tail), .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid = '0; alloc_rob_tag = '0; alloc_size = '0; alloc_data = '0;
      alloc_data_valid = '0; agu_valid = 0; agu_rob_tag = '0; agu_address = '0;
      cdb_active = 0; cdb_tag = '0; cdb_data = '0; commit_valid = '0; commit_tag = '0;
      flush = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_idx = '0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic alloc2(input logic [4:0] t0, input logic [4:0] t1);
      alloc_valid = 2'b11; alloc_rob_tag = {t1, t0}; alloc_size = {2'b10, 2'b10};
      alloc_data_valid = 2'b00;
      tick();
      alloc_valid = 2'b00;
   endtask

   task automatic wait_req(input int lim, output bit seen);
      seen = 0;
      for (int i = 0; i < lim && !seen; i++) begin
         tick();
         if (mem_req_valid) seen = 1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      logic [31:0] hold_addr;

      // Reset state
      reset_dut();
      chk("rst_head", head, 0);
      chk("rst_tail", tail, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_misaligned", misaligned, 0);

      // Dual allocation, then a word store through issue and retire
      alloc2(5'd3, 5'd4);
      chk("alloc_tail", tail, 2);
      chk("alloc_count", count, 2);
      chk("alloc_empty", empty, 0);
      agu_valid = 1; agu_rob_tag = 5'd3; agu_address = 32'h100;
      cdb_active = 1; cdb_tag = 5'd3; cdb_data = 32'hDEADBEEF;
      commit_valid = 2'b01; commit_tag = {5'd0, 5'd3};
      tick();
      idle_inputs();
      wait_req(10, seen);
      chk("w_req_seen", seen, 1);
      chk("w_req_addr", mem_req_addr, 32'h100);
      chk("w_req_mask", mem_req_mask, 4'b1111);
      chk("w_req_data", mem_req_data, 32'hDEADBEEF);
      chk("w_req_idx", mem_req_idx, 0);
      hold_addr = mem_req_addr;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", mem_req_valid, 1);
         chk("hold_addr", mem_req_addr, hold_addr);
         chk("hold_data", mem_req_data, 32'hDEADBEEF);
      end
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      chk("after_fire_valid", mem_req_valid, 0);
      tick();
      chk("no_reissue", mem_req_valid, 0);
      mem_resp_valid = 1; mem_resp_idx = 4'd0;
      tick();
      mem_resp_valid = 0;
      chk("pre_retire_head", head, 0);
      tick();
      chk("retire_head", head, 1);
      chk("retire_count", count, 1);

      // Byte store to 0x103, then a misaligned halfword
      reset_dut();
      alloc_valid = 2'b01; alloc_rob_tag = {5'd0, 5'd5}; alloc_size = {2'b00, 2'b00};
      alloc_data = {32'd0, 32'h000000AB}; alloc_data_valid = 2'b01;
      tick();
      idle_inputs();
      agu_valid = 1; agu_rob_tag = 5'd5; agu_address = 32'h103;
      commit_valid = 2'b01; commit_tag = {5'd0, 5'd5};
      tick();
      idle_inputs();
      chk("sb_no_misaligned", misaligned, 0);
      wait_req(10, seen);
      chk("sb_req_seen", seen, 1);
      chk("sb_mask", mem_req_mask, 4'b1000);
      chk("sb_data", mem_req_data, 32'hAB000000);
      chk("sb_addr", mem_req_addr, 32'h100);
      alloc_valid = 2'b01; alloc_rob_tag = {5'd0, 5'd6}; alloc_size = {2'b00, 2'b01};
      tick();
      idle_inputs();
      agu_valid = 1; agu_rob_tag = 5'd6; agu_address = 32'h101;
      tick();
      idle_inputs();
      chk("sh_misaligned", misaligned, 1);
      chk("sh_misaligned_tag", misaligned_rob_tag, 6);
      tick();
      chk("sh_misaligned_pulse", misaligned, 0);

      // Flush with two committed entries out of six
      reset_dut();
      alloc2(5'd0, 5'd1); alloc2(5'd2, 5'd3); alloc2(5'd4, 5'd5);
      chk("flush_pre_count", count, 6);
      commit_valid = 2'b11; commit_tag = {5'd1, 5'd0};
      tick();
      commit_valid = 2'b00;
      flush = 1;
      alloc_valid = 2'b11; alloc_rob_tag = {5'd21, 5'd20};
      tick();
      idle_inputs();
      chk("flush_tail", tail, 2);
      chk("flush_count", count, 2);
      chk("flush_head", head, 0);
      alloc_valid = 2'b01; alloc_rob_tag = {5'd0, 5'd9};
      tick();
      idle_inputs();
      chk("flush_realloc_tail", tail, 3);
      chk("flush_realloc_count", count, 3);

      // Flush with a same-cycle commit of tag 2
      reset_dut();
      alloc2(5'd0, 5'd1); alloc2(5'd2, 5'd3); alloc2(5'd4, 5'd5);
      commit_valid = 2'b11; commit_tag = {5'd1, 5'd0};
      tick();
      flush = 1; commit_valid = 2'b01; commit_tag = {5'd0, 5'd2};
      tick();
      idle_inputs();
      chk("flush_commit_tail", tail, 3);
      chk("flush_commit_count", count, 3);

      // Fill, then stream alloc/issue/retire so both pointers wrap
      reset_dut();
      begin
         int cnt_m = 0, tail_m = 0, head_m = 0, alloc_n = 0, agu_n = 0;
         bit fire_seen = 0, ret_next = 0, r_drv = 0, a_acc = 0, wrapped = 0;
         logic [3:0] fire_idx = '0, prev_head = '0;
         mem_req_ready = 1;
         for (int cyc = 0; cyc < 160; cyc++) begin
            alloc_valid      = (cyc < 60) ? 2'b11 : 2'b00;
            alloc_rob_tag    = {5'(alloc_n + 1), 5'(alloc_n)};
            alloc_size       = {2'b10, 2'b10};
            alloc_data       = {32'(alloc_n + 1), 32'(alloc_n)};
            alloc_data_valid = 2'b11;
            a_acc            = (cyc < 60) && (cnt_m <= 14);
            if (cyc >= 8 && agu_n < alloc_n) begin
               agu_valid = 1; agu_rob_tag = 5'(agu_n); agu_address = 32'h1000 + 32'(agu_n * 4);
               commit_valid = 2'b01; commit_tag = {5'd0, 5'(agu_n)};
               agu_n++;
            end else begin
               agu_valid = 0; commit_valid = 2'b00;
            end
            mem_resp_valid = fire_seen; mem_resp_idx = fire_idx; r_drv = fire_seen;
            fire_seen = mem_req_valid; fire_idx = mem_req_idx;
            tick();
            if (a_acc) begin
               cnt_m += 2; tail_m = (tail_m + 2) % 16; alloc_n += 2;
            end
            if (ret_next) begin
               cnt_m--; head_m = (head_m + 1) % 16;
            end
            ret_next = r_drv;
            chk("wrap_count", count, cnt_m);
            chk("wrap_head", head, head_m);
            chk("wrap_tail", tail, tail_m);
            chk("wrap_full", full, cnt_m == 16);
            chk("wrap_alloc_ready", alloc_ready, cnt_m <= 14);
            chk("wrap_count_le16", count <= 16, 1);
            if (head < prev_head) wrapped = 1;
            prev_head = head;
         end
         idle_inputs();
         chk("wrap_seen", wrapped, 1);
         chk("drain_count", count, 0);
         chk("drain_empty", empty, 1);
         chk("drain_ptrs", {head, tail}, {4'(head_m), 4'(tail_m)});
      end

      // Allocation racing a CDB broadcast for the same tag
      reset_dut();
      alloc_valid = 2'b01; alloc_rob_tag = {5'd0, 5'd7}; alloc_size = {2'b00, 2'b10};
      alloc_data_valid = 2'b00;
      cdb_active = 1; cdb_tag = 5'd7; cdb_data = 32'h55;
      tick();
      idle_inputs();
      agu_valid = 1; agu_rob_tag = 5'd7; agu_address = 32'h100;
      commit_valid = 2'b01; commit_tag = {5'd0, 5'd7};
      tick();
      idle_inputs();
      wait_req(8, seen);
`ifdef STQ_CDB_BYPASS_EN
      chk("bypass_req_seen", seen, 1);
      chk("bypass_data", mem_req_data, 32'h55);
`else
      chk("nobypass_req_seen", seen, 0);
      cdb_active = 1; cdb_tag = 5'd7; cdb_data = 32'h66;
      tick();
      idle_inputs();
      wait_req(8, seen);
      chk("late_cdb_req_seen", seen, 1);
      chk("late_cdb_data", mem_req_data, 32'h66);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
